// File: rtl/uart_rx_param_if.sv
// Received-word channel of uart_rx_param: data/valid/ready plus the one-cycle
// error pulses and the receiver FSM state for observation.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rxData;
  logic                 rxValid;
  logic                 rxReady;
  logic                 frameError;
  logic                 parityError;
  logic                 overrunError;
  logic [2:0]           rxState;

  // Handshake: a word transfers on every clock where rxValid && rxReady are
  // both high; rxData is held stable while rxValid=1 and the word is unread.
  modport master (
    output rxData, rxValid, frameError, parityError, overrunError, rxState,
    input  rxReady
  );
  modport slave (
    input  rxData, rxValid, frameError, parityError, overrunError, rxState,
    output rxReady
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with false-start rejection, framing
// and overrun detection; optional parity check enabled by UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DIVISOR    = 52,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             uartRxPin,
  uart_rx_param_if.master  rx_if
);
  localparam int DIV_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TCNT_W = $clog2(OVERSAMPLE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 sync1_q, sync2_q;
  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 deliver_q, deliver_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 tick, sample_pt, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_W'(DIVISOR - 1));
  // The start bit is checked at its middle; after that every full bit period.
  assign sample_pt = tick && ((state_q == S_START) ? (tcnt_q == TCNT_W'(OVERSAMPLE/2 - 1))
                                                   : (tcnt_q == TCNT_W'(OVERSAMPLE - 1)));

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (state_q == S_IDLE) begin
      div_d  = '0;
      tcnt_d = '0;
    end else begin
      div_d  = tick ? '0 : div_q + 1'b1;
      tcnt_d = tick ? tcnt_q + 1'b1 : tcnt_q;
    end
    if (sample_pt) tcnt_d = '0;

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) state_d = S_START;
      end
      S_START: if (sample_pt) begin
        state_d = rx_s ? S_IDLE : S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (sample_pt) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (sample_pt) begin
        par_bad_d = (rx_s != ((^shift_q) ^ PARITY_ODD[0]));
        state_d   = S_STOP;
      end
`endif
      S_STOP: if (sample_pt) begin
        if (!rx_s) begin
          ferr_d  = 1'b1;
          state_d = S_BREAK;
        end else if (bit_q == 4'(STOP_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) perr_d = 1'b1;
          else deliver_d = 1'b1;
`else
          deliver_d = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle as a delivery frees the slot, so no overrun.
    if (valid_q && rx_if.rxReady) valid_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || rx_if.rxReady) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      tcnt_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      deliver_q <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= uartRxPin;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tcnt_q    <= tcnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      deliver_q <= deliver_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_if.rxData       = data_q;
  assign rx_if.rxValid      = valid_q;
  assign rx_if.frameError   = ferr_q;
  assign rx_if.overrunError = oerr_q;
  assign rx_if.rxState      = state_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parityError  = perr_q;
`else
  assign rx_if.parityError  = 1'b0;
  wire unused_parity_cfg = ^PARITY_ODD;
`endif
endmodule
